universal_shift_register: RTL and testbench

Registered N-bit (default 4) universal shift register with an 8-way synchronous mode select: hold, logical shift in either direction, parallel load, bitwise complement, rotate in either direction, and half-word swap. It is a general-purpose datapath primitive that sits between a control FSM driving the mode select and any consumer of the registered word. Each bit is a flop fed by an 8:1 selection of neighbouring bits.

---
 rtl/usr_pkg.sv | 16 +
 rtl/usr_bit_mux.sv | 27 ++
 rtl/universal_shift_register.sv | 87 ++++++++
 tb/tb_universal_shift_register.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register.
// Mode encodings and the mode select type.
package usr_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_HOLD = 3'b000;
    localparam mode_t MODE_SHL  = 3'b001;
    localparam mode_t MODE_SHR  = 3'b010;
    localparam mode_t MODE_LOAD = 3'b011;
    localparam mode_t MODE_INV  = 3'b100;
    localparam mode_t MODE_ROL  = 3'b101;
    localparam mode_t MODE_ROR  = 3'b110;
    localparam mode_t MODE_SWAP = 3'b111;

endpackage

// File: rtl/usr_bit_mux.sv
// 8:1 single-bit selector feeding one register bit.
// Input d is ordered by mode encoding: d[MODE_x] is chosen for mode x.
module usr_bit_mux
    import usr_pkg::*;
(
    input  mode_t      i_sel,
    input  logic [7:0] i_d,
    output logic       o_y
);

    // Pick the candidate next-bit value for the selected mode
    always_comb begin
        o_y = 1'b0;
        case (i_sel)
            MODE_HOLD: o_y = i_d[0];
            MODE_SHL:  o_y = i_d[1];
            MODE_SHR:  o_y = i_d[2];
            MODE_LOAD: o_y = i_d[3];
            MODE_INV:  o_y = i_d[4];
            MODE_ROL:  o_y = i_d[5];
            MODE_ROR:  o_y = i_d[6];
            MODE_SWAP: o_y = i_d[7];
            default:   o_y = i_d[0];
        endcase
    end

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register with 8-way mode select and sync clear.
// Optional USR_SERIAL_IN_EN adds serial fill inputs for the two shift modes.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [2:0]       S,
    input  logic [WIDTH-1:0] I,
`ifdef USR_SERIAL_IN_EN
    input  logic             sin_up,
    input  logic             sin_down,
`endif
    output logic [WIDTH-1:0] O
);

    localparam int HALF = WIDTH / 2;

    logic             w_fill_up;
    logic             w_fill_dn;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_up;
    logic [WIDTH-1:0] w_dn;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_swp;
    mode_t            w_mode;

`ifdef USR_SERIAL_IN_EN
    assign w_fill_up = sin_up;
    assign w_fill_dn = sin_down;
`else
    assign w_fill_up = 1'b0;
    assign w_fill_dn = 1'b0;
`endif

    assign w_mode = mode_t'(S);

    // Neighbour-bit views of the current word, one per moving mode
    assign w_up  = {w_q[WIDTH-2:0], w_fill_up};
    assign w_dn  = {w_fill_dn, w_q[WIDTH-1:1]};
    assign w_rol = {w_q[WIDTH-2:0], w_q[WIDTH-1]};
    assign w_ror = {w_q[0], w_q[WIDTH-1:1]};
    assign w_swp = {w_q[HALF-1:0], w_q[WIDTH-1:HALF]};

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_bit
            logic       r_bit;
            logic       w_nxt;
            logic [7:0] w_cand;

            assign w_cand = {
                w_swp[g],
                w_ror[g],
                w_rol[g],
                ~w_q[g],
                I[g],
                w_dn[g],
                w_up[g],
                w_q[g]
            };

            usr_bit_mux u_mux (
                .i_sel (w_mode),
                .i_d   (w_cand),
                .o_y   (w_nxt)
            );

            // Register bit with clear taking priority over any mode
            always_ff @(posedge clk) begin
                if (clear) begin
                    r_bit <= 1'b0;
                end else begin
                    r_bit <= w_nxt;
                end
            end

            assign w_q[g] = r_bit;
        end
    endgenerate

    assign O = w_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register (WIDTH=4 and WIDTH=8).
// Arithmetic reference model compared every cycle, plus literal pins.
module tb_universal_shift_register;

    logic       clk;
    logic       clear;
    logic [2:0] S;
    logic [3:0] I;
    logic [3:0] O;
    logic       su;
    logic       sd;

    logic       clr8;
    logic [2:0] s8;
    logic [7:0] i8;
    logic [7:0] o8;

    logic [3:0] m4;
    logic [7:0] m8;
    bit         mv4;
    bit         mv8;

    int checks;
    int errors;

    universal_shift_register #(.WIDTH(4)) u_dut (
        .clk      (clk),
        .clear    (clear),
        .S        (S),
        .I        (I),
`ifdef USR_SERIAL_IN_EN
        .sin_up   (su),
        .sin_down (sd),
`endif
        .O        (O)
    );

    universal_shift_register #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .clear    (clr8),
        .S        (s8),
        .I        (i8),
`ifdef USR_SERIAL_IN_EN
        .sin_up   (1'b0),
        .sin_down (1'b0),
`endif
        .O        (o8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] nxt(
        input int         w,
        input logic [7:0] o,
        input logic [2:0] s,
        input logic [7:0] i,
        input logic       up,
        input logic       dn
    );
        int msk;
        int v;
        int h;
        int r;
        msk = (1 << w) - 1;
        v = int'(o) & msk;
        h = w / 2;
        r = v;
        case (s)
            3'd0: r = v;
            3'd1: r = (v << 1) | int'(up);
            3'd2: r = (v >> 1) | (int'(dn) << (w - 1));
            3'd3: r = int'(i);
            3'd4: r = ~v;
            3'd5: r = (v << 1) | (v >> (w - 1));
            3'd6: r = (v >> 1) | ((v & 1) << (w - 1));
            default: r = (v << h) | (v >> h);
        endcase
        return 8'(r & msk);
    endfunction

    // Reference model advances on the same edge as the DUT
    always @(posedge clk) begin
        if (clear) begin
            m4  <= 4'd0;
            mv4 <= 1'b1;
        end else begin
            m4 <= 4'(nxt(4, {4'd0, m4}, S, {4'd0, I}, su, sd));
        end
        if (clr8) begin
            m8  <= 8'd0;
            mv8 <= 1'b1;
        end else begin
            m8 <= nxt(8, m8, s8, i8, 1'b0, 1'b0);
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (mv4) begin
            checks++;
            if (O !== m4) begin
                errors++;
                $display("FAIL model4 t=%0t got %b exp %b", $time, O, m4);
            end
        end
        if (mv8) begin
            checks++;
            if (o8 !== m8) begin
                errors++;
                $display("FAIL model8 t=%0t got %h exp %h", $time, o8, m8);
            end
        end
    end

    task automatic step(
        input logic       c,
        input logic [2:0] s,
        input logic [3:0] i,
        input bit         chk,
        input logic [3:0] exp,
        input string      name
    );
        clear = c;
        S     = s;
        I     = i;
        @(posedge clk);
        #1;
        if (chk) begin
            checks++;
            if (O !== exp) begin
                errors++;
                $display("FAIL %s dut got %b exp %b", name, O, exp);
            end
            checks++;
            if (m4 !== exp) begin
                errors++;
                $display("FAIL %s model got %b exp %b", name, m4, exp);
            end
        end
    endtask

    task automatic step8(
        input logic       c,
        input logic [2:0] s,
        input logic [7:0] i,
        input bit         chk,
        input logic [7:0] exp,
        input string      name
    );
        clr8 = c;
        s8   = s;
        i8   = i;
        @(posedge clk);
        #1;
        if (chk) begin
            checks++;
            if (o8 !== exp) begin
                errors++;
                $display("FAIL %s dut got %h exp %h", name, o8, exp);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mv4    = 1'b0;
        mv8    = 1'b0;
        clear  = 1'b1;
        S      = 3'b011;
        I      = 4'b1001;
        su     = 1'b0;
        sd     = 1'b0;
        clr8   = 1'b1;
        s8     = 3'b000;
        i8     = 8'h00;

        step(1'b1, 3'b011, 4'b1001, 1, 4'b0000, "reset");
        step(1'b0, 3'b011, 4'b1001, 1, 4'b1001, "load");
        step(1'b0, 3'b100, 4'b0000, 1, 4'b0110, "inv");
        step(1'b0, 3'b111, 4'b0000, 1, 4'b1001, "swap");
        step(1'b0, 3'b110, 4'b0000, 1, 4'b1100, "ror");
        step(1'b0, 3'b101, 4'b0000, 1, 4'b1001, "rol");
        step(1'b0, 3'b010, 4'b0000, 1, 4'b0100, "shr");
        step(1'b0, 3'b001, 4'b0000, 1, 4'b1000, "shl");
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 3'b000, 4'b0101, 1, 4'b1000, "hold");
        end
        step(1'b0, 3'b011, 4'b1111, 1, 4'b1111, "load_ones");
        step(1'b1, 3'b101, 4'b0000, 1, 4'b0000, "clear_mid");
        step(1'b0, 3'b100, 4'b0000, 1, 4'b1111, "inv_after_clear");
        step(1'b0, 3'b001, 4'b0000, 1, 4'b1110, "shl_zero_fill");
        step(1'b0, 3'b010, 4'b0000, 1, 4'b0111, "shr_zero_fill");

        for (int k = 0; k < 24; k++) begin
            step((k == 13), 3'(k % 8), 4'((k * 7 + 3) % 16), 0, 4'd0, "sweep");
        end

`ifdef USR_SERIAL_IN_EN
        step(1'b1, 3'b000, 4'b0000, 1, 4'b0000, "ser_clear");
        su = 1'b1;
        step(1'b0, 3'b001, 4'b0000, 1, 4'b0001, "ser_up1");
        step(1'b0, 3'b001, 4'b0000, 1, 4'b0011, "ser_up2");
        step(1'b0, 3'b001, 4'b0000, 1, 4'b0111, "ser_up3");
        step(1'b0, 3'b001, 4'b0000, 1, 4'b1111, "ser_up4");
        su = 1'b0;
        sd = 1'b0;
        step(1'b0, 3'b010, 4'b0000, 1, 4'b0111, "ser_dn0");
        sd = 1'b1;
        step(1'b0, 3'b010, 4'b0000, 1, 4'b1011, "ser_dn1");
        sd = 1'b0;
`endif

        step8(1'b1, 3'b000, 8'h00, 1, 8'h00, "w8_reset");
        step8(1'b0, 3'b011, 8'h1E, 1, 8'h1E, "w8_load");
        step8(1'b0, 3'b111, 8'h00, 1, 8'hE1, "w8_swap");
        step8(1'b0, 3'b101, 8'h00, 1, 8'hC3, "w8_rol");
        step8(1'b0, 3'b110, 8'h00, 1, 8'hE1, "w8_ror");
        step8(1'b0, 3'b010, 8'h00, 1, 8'h70, "w8_shr");

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
